// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS encodings, instruction field layout and fetch state
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_TYPE_R = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FUNC_SLL  = 6'b000000;
    localparam logic [5:0] FUNC_JR   = 6'b001000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;

    // R-type view of a word; imm and target overlay the low 16 and 26 bits.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } inst_t;

    typedef enum logic [0:0] {
        FETCH_REQ   = 1'b0,
        FETCH_VALID = 1'b1
    } fetch_state_e;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_jump_predecode.sv
// ============================================================================
//  Module      : jump_predecode
//  Description : Combinational J/JAL detection and pseudo-direct target build
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module jump_predecode
    import mips_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc_plus4,
    output logic        o_is_jump,
    output logic [31:0] o_jump_target
);

    inst_t w_fields;

    assign w_fields  = inst_t'(i_inst);
    assign o_is_jump = is_jump_op(w_fields.opcode);

    // Target keeps the 256 MB region of the delay-slot address (pc+4).
    assign o_jump_target = (i_pc_plus4 & 32'hF000_0000)
                         | {4'b0000, w_fields.rs, w_fields.rt, w_fields.rd,
                            w_fields.shamt, w_fields.func, 2'b00};

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
//  Module      : inst_fetch
//  Description : PC owner; fetches words over req/ack and presents split fields
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam logic [0:0] c_st_req   = FETCH_REQ;
    localparam logic [0:0] c_st_valid = FETCH_VALID;

    logic [0:0]  r_state;
    logic        r_req;
    logic        r_kill;
    logic [31:0] r_pc;
    logic [31:0] r_pc_pend;
    logic [31:0] r_inst;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_is_jump;
    logic [31:0] w_jump_target;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = redirect_pc & ~32'h3;

    jump_predecode u_jump_predecode (
        .i_inst        (r_inst),
        .i_pc_plus4    (w_pc_plus4),
        .o_is_jump     (w_is_jump),
        .o_jump_target (w_jump_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_req;
            r_req     <= 1'b0;
            r_kill    <= 1'b0;
            r_pc      <= RESET_PC;
            r_pc_pend <= RESET_PC;
            r_inst    <= '0;
        end else begin
            case (r_state)
                c_st_req: begin
                    if (!r_req) begin
                        // No request outstanding, so a redirect can retarget directly.
                        r_req <= 1'b1;
                        if (redirect) begin
                            r_pc <= w_redirect_pc;
                        end
                    end else if (imem_ack) begin
                        r_req <= 1'b0;
                        if (redirect) begin
                            r_pc   <= w_redirect_pc;
                            r_kill <= 1'b0;
                        end else if (r_kill) begin
                            r_pc   <= r_pc_pend;
                            r_kill <= 1'b0;
                        end else begin
                            r_inst  <= imem_rdata;
                            r_state <= c_st_valid;
                        end
                    end else if (redirect) begin
                        // Address must stay stable until imem answers; remember the target.
                        r_kill    <= 1'b1;
                        r_pc_pend <= w_redirect_pc;
                    end
                end
                c_st_valid: begin
                    if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_req   <= 1'b1;
                        r_state <= c_st_req;
                    end else if (!stall) begin
                        r_pc    <= w_is_jump ? w_jump_target : w_pc_plus4;
                        r_req   <= 1'b1;
                        r_state <= c_st_req;
                    end
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == c_st_valid);
    assign inst       = r_inst;
    assign opcode     = r_inst[31:26];
    assign rs         = r_inst[25:21];
    assign rt         = r_inst[20:16];
    assign rd         = r_inst[15:11];
    assign func       = r_inst[5:0];
    assign imm        = r_inst[15:0];
    assign target     = r_inst[25:0];
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Scoreboard bench for inst_fetch with a random imem and decoder
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    localparam logic [31:0] c_reset_pc = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(c_reset_pc)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target), .pc(pc), .pc_plus4(pc_plus4)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_cur_pc = '0;
    logic [31:0] m_cur_inst = '0;
    logic        run = 1'b0;
    logic        dir_stall = 1'b0;
    logic        mon_en = 1'b0;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == c_reset_pc)         return 32'h2408_0005;
        if (a == c_reset_pc + 32'd4) return 32'h0109_5021;
        if (a == 32'h0)              return 32'h0C00_0010;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 13) ^ (h << 7);
        if (a[6:4] == 3'b010) return {5'b00001, h[26:0]};
        if (h[31:27] == 5'b00001) h[30] = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] w);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (w[31:27] == 5'b00001) return {p4[31:28], w[25:0], 2'b00};
        return p4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout actual=no_req required=req", name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (inst_valid) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout actual=no_valid required=valid", name);
    endtask

    // Instruction memory: random latency 0..3, occasional stray acks while idle.
    initial begin : p_imem
        int cnt, dly;
        cnt = 0; dly = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                imem_ack = 1'b0; cnt = 0;
            end else if (imem_req) begin
                if (cnt >= dly) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt = 0;
                    dly = $urandom_range(0, 3);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom();
                    cnt++;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 7) == 0);
                imem_rdata = $urandom();
                cnt = 0;
            end
        end
    end

    // Decoder side stimulus and the reference model of the delivered PC stream.
    initial begin : p_stim
        forever begin
            @(negedge clk); #1;
            if (run) begin
                stall    = ($urandom_range(0, 2) == 0);
                redirect = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 1) == 1) redirect_pc = $urandom_range(0, 255);
                else                           redirect_pc = $urandom();
            end else begin
                stall    = dir_stall;
                redirect = 1'b0;
            end
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(c_reset_pc);
            end else if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'h3);
            end else if (inst_valid && !stall) begin
                exp_q.push_back(next_pc(m_cur_pc, m_cur_inst));
            end
        end
    end

    // Monitor: scoreboard pop on each new instruction plus handshake rules.
    initial begin : p_mon
        logic        prev_valid, prev_req;
        logic [31:0] prev_addr, prev_inst, prev_pc, e;
        int          idle;
        prev_valid = 0; prev_req = 0; prev_addr = '0; prev_inst = '0; prev_pc = '0; idle = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_valid = 0; prev_req = 0; idle = 0;
                continue;
            end
            if (prev_req && !imem_ack && !rst)
                check("req_hold", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, prev_addr});
            if (prev_valid && stall && !redirect) begin
                check("stall_freeze", {30'd0, inst_valid, imem_req, inst}, {30'd0, 2'b10, prev_inst});
                check("stall_pc", {32'd0, pc}, {32'd0, prev_pc});
            end
            if (prev_valid && (redirect || !stall))
                check("leave_valid", {62'd0, inst_valid, imem_req}, {62'd0, 2'b01});
            if (inst_valid && !prev_valid) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL deliver_unexpected actual=%0h required=none", pc);
                end else begin
                    e = exp_q.pop_front();
                    m_cur_pc   = e;
                    m_cur_inst = mem_word(e);
                    check("deliver_pc", {32'd0, pc}, {32'd0, e});
                    check("deliver_inst", {32'd0, inst}, {32'd0, m_cur_inst});
                    check("deliver_pc4", {32'd0, pc_plus4}, {32'd0, e + 32'd4});
                    check("fields_a", {37'd0, opcode, func, rs, rt, rd},
                          {37'd0, m_cur_inst[31:26], m_cur_inst[5:0], m_cur_inst[25:21],
                           m_cur_inst[20:16], m_cur_inst[15:11]});
                    check("fields_b", {22'd0, imm, target},
                          {22'd0, m_cur_inst[15:0], m_cur_inst[25:0]});
                end
            end else if (!inst_valid) begin
                idle++;
                if (idle > 100) begin
                    checks++; errors++;
                    $display("FAIL progress_timeout actual=idle required=delivery");
                    idle = 0;
                end
            end
            prev_valid = inst_valid;
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_inst  = inst;
            prev_pc    = pc;
        end
    end

    initial begin : p_main
        logic [31:0] held;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, imem_req, inst_valid, inst}, 64'd0);
        check("reset_pc", {32'd0, pc}, {32'd0, c_reset_pc});
        #2 rst = 1'b0; mon_en = 1'b1;

        @(negedge clk);
        check("first_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, c_reset_pc});
        @(negedge clk);
        check("first_valid", {63'd0, inst_valid}, 64'd1);
        check("addiu_fields", {48'd0, opcode, rt, imm[4:0]}, {48'd0, 6'b001001, 5'd8, 5'd5});
        check("addiu_pc4", {pc, pc_plus4}, {c_reset_pc, c_reset_pc + 32'd4});
        #2 dir_stall = 1'b1;
        @(negedge clk);
        check("second_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC});

        wait_valid("addu_valid");
        check("addu_fields", {53'd0, func, rd}, {53'd0, 6'b100001, 5'd10});
        held = inst;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("addu_hold", {30'd0, inst_valid, imem_req, inst}, {30'd0, 2'b10, held});
        end
        #2 dir_stall = 1'b0;
        wait_req("wrap_req");
        check("wrap_addr", {32'd0, imem_addr}, 64'd0);

        wait_valid("jal_valid");
        check("jal_fields", {opcode, pc_plus4}, {6'b000011, 32'h4});
        wait_req("jal_req");
        check("jal_target", {32'd0, imem_addr}, 64'h40);

        #2 run = 1'b1;
        repeat (3000) @(negedge clk);
        #2 run = 1'b0;

        wait_req("mid_req");
        #2 rst = 1'b1; mon_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(c_reset_pc);
        @(negedge clk);
        check("mid_reset", {62'd0, imem_req, inst_valid}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0; mon_en = 1'b1;
        wait_req("restart_req");
        check("restart_addr", {32'd0, imem_addr}, {32'd0, c_reset_pc});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
